// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit LFSR pattern generator: seeds, locks, counts misses.
// Optional LFSR_CHK_BITERR_EN: a mismatch adds its bit-error count instead of 1.
module lfsr_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_val,
    input  logic [7:0]       in_data,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    localparam int SW = ERR_W + 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       pred_q, pred_d;
    logic [MW-1:0]    match_q, match_d;
    logic [LW-1:0]    miss_q, miss_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic             bump;
    logic [3:0]       inc;
    logic [SW-1:0]    sum;

    function automatic logic [7:0] nxt(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [3:0] popcnt(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

`ifdef LFSR_CHK_BITERR_EN
    assign inc = popcnt(in_data ^ pred_q);
`else
    assign inc = 4'd1;
`endif

    assign sum = SW'(cnt_q) + SW'(inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            pred_q  <= 8'h00;
            match_q <= '0;
            miss_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pred_q  <= pred_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        bump    = 1'b0;
        if (in_val) begin
            unique case (state_q)
                HUNT: begin
                    if (in_data != 8'h00) begin
                        pred_d  = nxt(in_data);
                        match_d = '0;
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (in_data == pred_q) begin
                        pred_d = nxt(pred_q);
                        if (match_q == MW'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else if (in_data != 8'h00) begin
                        pred_d  = nxt(in_data);
                        match_d = '0;
                    end else begin
                        state_d = HUNT;
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the received word never reseeds once locked
                    pred_d = nxt(pred_q);
                    if (in_data == pred_q) begin
                        miss_d = '0;
                    end else begin
                        err_d = 1'b1;
                        bump  = 1'b1;
                        if (miss_q == LW'(LOSS_CNT - 1)) begin
                            state_d = HUNT;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        if (clr) begin
            cnt_d = '0;
        end else if (bump) begin
            if (sum > SW'({ERR_W{1'b1}})) cnt_d = {ERR_W{1'b1}};
            else                          cnt_d = sum[ERR_W-1:0];
        end
    end

    assign locked  = (state_q == LOCKED);
    assign err     = err_q;
    assign err_cnt = cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: reference model queues expected outputs per word.
// Expected error weights follow LFSR_CHK_BITERR_EN when it is defined.
module tb_lfsr_checker;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;
    localparam int ERR_W    = 4;
    localparam int CMAX     = (1 << ERR_W) - 1;

    typedef struct {
        logic       locked;
        logic       err;
        logic [ERR_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             in_val;
    logic [7:0]       in_data;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_cnt;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int         m_st;
    logic [7:0] m_pred;
    int         m_match;
    int         m_miss;
    int         m_cnt;

    lfsr_checker #(
        .LOCK_CNT(LOCK_CNT),
        .LOSS_CNT(LOSS_CNT),
        .ERR_W   (ERR_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .in_val (in_val),
        .in_data(in_data),
        .locked (locked),
        .err    (err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        logic fb;
        fb = (s[7] ~^ s[5]) ^ (s[4] ~^ s[3]);
        return {s[6:0], fb};
    endfunction

    function automatic int weight(input logic [7:0] a, input logic [7:0] b);
`ifdef LFSR_CHK_BITERR_EN
        return $countones(a ^ b);
`else
        return 1;
`endif
    endfunction

    task automatic model_reset();
        m_st    = 0;
        m_pred  = 8'h00;
        m_match = 0;
        m_miss  = 0;
        m_cnt   = 0;
        sb.delete();
    endtask

    task automatic model(input logic v, input logic [7:0] d, input logic c);
        exp_t e;
        e.err = 1'b0;
        if (v) begin
            if (m_st == 0) begin
                if (d != 8'h00) begin
                    m_pred  = lfsr_next(d);
                    m_match = 0;
                    m_st    = 1;
                end
            end else if (m_st == 1) begin
                if (d == m_pred) begin
                    m_pred  = lfsr_next(m_pred);
                    m_match = m_match + 1;
                    if (m_match == LOCK_CNT) begin
                        m_st   = 2;
                        m_miss = 0;
                    end
                end else if (d != 8'h00) begin
                    m_pred  = lfsr_next(d);
                    m_match = 0;
                end else begin
                    m_st = 0;
                end
            end else begin
                if (d == m_pred) begin
                    m_miss = 0;
                end else begin
                    e.err  = 1'b1;
                    m_cnt  = m_cnt + weight(d, m_pred);
                    if (m_cnt > CMAX) m_cnt = CMAX;
                    m_miss = m_miss + 1;
                    if (m_miss == LOSS_CNT) begin
                        m_st   = 0;
                        m_miss = 0;
                    end
                end
                m_pred = lfsr_next(m_pred);
            end
        end
        if (c) m_cnt = 0;
        e.locked = (m_st == 2);
        e.cnt    = m_cnt[ERR_W-1:0];
        sb.push_back(e);
    endtask

    task automatic send(input logic v, input logic [7:0] d, input logic c);
        exp_t e;
        in_val  = v;
        in_data = d;
        clr     = c;
        model(v, d, c);
        @(posedge clk);
        #1;
        in_val = 1'b0;
        clr    = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (locked !== e.locked || err !== e.err || err_cnt !== e.cnt) begin
            n_fail++;
            $display("FAIL word %02h v=%0b: got locked=%0b err=%0b cnt=%0d, want locked=%0b err=%0b cnt=%0d",
                     d, v, locked, err, err_cnt, e.locked, e.err, e.cnt);
        end
    endtask

    task automatic send_seq(input logic [7:0] s, input int n);
        logic [7:0] w;
        w = s;
        for (int i = 0; i < n; i++) begin
            send(1'b1, w, 1'b0);
            w = lfsr_next(w);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        clr     = 1'b0;
        in_val  = 1'b0;
        in_data = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset: got locked=%0b err=%0b cnt=%0d, want 0 0 0", locked, err, err_cnt);
        end
        rst = 1'b0;
        send(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_lock();
        send(1'b1, 8'h5A, 1'b0);
        send(1'b1, 8'hB4, 1'b0);
        send(1'b1, 8'h69, 1'b0);
        send(1'b1, 8'hD2, 1'b0);
        n_tests++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL early_lock: got locked=%0b want 0", locked);
        end
        send(1'b1, 8'hA4, 1'b0);
        n_tests++;
        if (locked !== 1'b1 || err_cnt !== '0) begin
            n_fail++;
            $display("FAIL lock: got locked=%0b cnt=%0d want 1 0", locked, err_cnt);
        end
    endtask

    task automatic test_gap();
        for (int i = 0; i < 5; i++) send(1'b0, 8'($urandom_range(0, 255)), 1'b0);
        send(1'b1, 8'h48, 1'b0);
        n_tests++;
        if (locked !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL gap: got locked=%0b err=%0b want 1 0", locked, err);
        end
    endtask

    task automatic test_single_err();
        logic [7:0] w;
        w = lfsr_next(8'h48);
        send(1'b1, w ^ 8'h01, 1'b0);
        send_seq(lfsr_next(w), 2);
        n_tests++;
        if (err_cnt !== 4'd1 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL single_err: got cnt=%0d locked=%0b want 1 1", err_cnt, locked);
        end
    endtask

    task automatic test_loss();
        int want;
`ifdef LFSR_CHK_BITERR_EN
        want = 10;
`else
        want = 4;
`endif
        for (int i = 0; i < 3; i++) send(1'b1, m_pred ^ 8'h07, 1'b0);
        n_tests++;
        if (locked !== 1'b0 || err_cnt !== want[ERR_W-1:0] || dut.state_q !== 2'd0) begin
            n_fail++;
            $display("FAIL loss: got locked=%0b cnt=%0d want 0 %0d", locked, err_cnt, want);
        end
    endtask

    task automatic test_zero_hunt();
        send(1'b1, 8'h00, 1'b0);
        send(1'b1, 8'h00, 1'b0);
        send_seq(8'h5A, 4);
        n_tests++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_early: got locked=%0b want 0", locked);
        end
        send(1'b1, 8'hA4, 1'b0);
        n_tests++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_lock: got locked=%0b want 1", locked);
        end
    endtask

    task automatic test_saturate_clr();
        int guard;
        guard = 0;
        while (m_cnt < CMAX && guard < 40) begin
            send(1'b1, m_pred ^ 8'h01, 1'b0);
            send(1'b1, m_pred, 1'b0);
            guard++;
        end
        send(1'b1, m_pred ^ 8'h01, 1'b0);
        n_tests++;
        if (err_cnt !== 4'hF) begin
            n_fail++;
            $display("FAIL saturate: got cnt=%0d want 15", err_cnt);
        end
        send(1'b1, m_pred, 1'b0);
        send(1'b1, m_pred ^ 8'h01, 1'b1);
        n_tests++;
        if (err_cnt !== '0 || locked !== 1'b1 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL clr: got cnt=%0d locked=%0b err=%0b want 0 1 1", err_cnt, locked, err);
        end
        send(1'b1, m_pred, 1'b0);
        send(1'b1, m_pred ^ 8'h01, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== '0) begin
            n_fail++;
            $display("FAIL async_rst: got locked=%0b err=%0b cnt=%0d want 0 0 0", locked, err, err_cnt);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_seq(8'h5A, 5);
        n_tests++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL relock: got locked=%0b want 1", locked);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_gap();
        test_single_err();
        test_loss();
        test_zero_hunt();
        test_saturate_clr();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
